// File: rtl/led_pattern_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_pattern_sequencer_pkg
// Description : Shared widths and sequencer state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package led_pattern_sequencer_pkg;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 4;

  // Sequencer states: IDLE, WAIT (ROM samples address), LOAD (ROM data valid),
  // SHOW (pattern held on the LEDs)
  localparam int              ST_W       = 2;
  localparam logic [ST_W-1:0] C_ST_IDLE  = 2'd0;
  localparam logic [ST_W-1:0] C_ST_WAIT  = 2'd1;
  localparam logic [ST_W-1:0] C_ST_LOAD  = 2'd2;
  localparam logic [ST_W-1:0] C_ST_SHOW  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/led_pattern_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : led_pattern_sequencer_if
// Description : Control, ROM and LED signals of the pattern sequencer.
//               master = environment (control FSM + ROM), slave = sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface led_pattern_sequencer_if #(
  parameter int ADDR_W = led_pattern_sequencer_pkg::DEF_ADDR_W,
  parameter int DATA_W = led_pattern_sequencer_pkg::DEF_DATA_W
);

  logic              start;
  logic              stop;
  logic              loop_en;
  logic [DATA_W-1:0] rom_data;
  logic [ADDR_W-1:0] rom_address;
  logic [DATA_W-1:0] leds;
  logic              busy;
  logic              done;

  modport master (
    output start, stop, loop_en, rom_data,
    input  rom_address, leds, busy, done
  );

  modport slave (
    input  start, stop, loop_en, rom_data,
    output rom_address, leds, busy, done
  );

endinterface
`default_nettype wire

// File: rtl/led_pattern_sequencer_hold_timer.sv
`default_nettype none
// ============================================================================
// Module      : led_pattern_sequencer_hold_timer
// Description : Hold counter for one displayed pattern. tc is high while the
//               count equals HOLD_CYCLES-1, i.e. on the last hold clock.
// Revision    : 1.0 - initial release
// ============================================================================
module led_pattern_sequencer_hold_timer #(
  parameter int HOLD_CYCLES = 1000
) (
  input  wire logic clock,
  input  wire logic reset,
  input  wire logic clear,
  input  wire logic enable,
  output logic      tc
);

  // One extra code above HOLD_CYCLES-1 so the count can step past the
  // terminal value on the decision clock without wrapping.
  localparam int CNT_W = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);

  logic [CNT_W-1:0] r_count;

  // Clear has priority over enable; the count only advances while enabled
  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign tc = (r_count == CNT_W'(HOLD_CYCLES - 1));

endmodule
`default_nettype wire

// File: rtl/led_pattern_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : led_pattern_sequencer
// Description : Walks LED pattern ROM addresses 0..LAST_ADDR, latches each
//               pattern after the ROM read latency and holds it HOLD_CYCLES
//               clocks; loops or ends with a one-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module led_pattern_sequencer
  import led_pattern_sequencer_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int LAST_ADDR   = 7,
  parameter int HOLD_CYCLES = 1000
) (
  input  wire logic              clock,
  input  wire logic              reset,
  led_pattern_sequencer_if.slave bus
);

  logic [ST_W-1:0]   r_state;
  logic [ST_W-1:0]   w_next_state;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_leds;
  logic              r_done;

  logic w_tc;
  logic w_last;
  logic w_step_end;
  logic w_timer_clr;
  logic w_timer_en;
  logic w_addr_clr;
  logic w_addr_inc;
  logic w_leds_clr;
  logic w_leds_load;
  logic w_done_set;

  assign w_last = (r_addr == ADDR_W'(LAST_ADDR));

  led_pattern_sequencer_hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_hold_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (w_timer_clr),
    .enable (w_timer_en),
    .tc     (w_tc)
  );

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= C_ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; stop aborts any non-idle state
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      C_ST_IDLE: if (bus.start && !bus.stop) w_next_state = C_ST_WAIT;
      C_ST_WAIT: w_next_state = bus.stop ? C_ST_IDLE : C_ST_LOAD;
      C_ST_LOAD: w_next_state = bus.stop ? C_ST_IDLE : C_ST_SHOW;
      C_ST_SHOW: begin
        if (bus.stop) begin
          w_next_state = C_ST_IDLE;
        end else if (w_tc) begin
          w_next_state = (w_last && !bus.loop_en) ? C_ST_IDLE : C_ST_WAIT;
        end
      end
      default:   w_next_state = C_ST_IDLE;
    endcase
  end

  // Output/control decode; loop_en only matters at the last-address decision
  always_comb begin
    w_timer_clr = (r_state == C_ST_LOAD);
    w_timer_en  = (r_state == C_ST_SHOW);
    w_step_end  = (r_state == C_ST_SHOW) && w_tc && !bus.stop;
    w_leds_clr  = (r_state != C_ST_IDLE) && bus.stop;
    w_leds_load = (r_state == C_ST_LOAD) && !bus.stop;
    w_addr_inc  = w_step_end && !w_last;
    w_done_set  = w_step_end && w_last && !bus.loop_en;
    w_addr_clr  = ((r_state == C_ST_IDLE) && bus.start && !bus.stop)
                || w_leds_clr
                || (w_step_end && w_last && bus.loop_en);
  end

  // ROM address register; the wrap to 0 is explicit so no overflow occurs
  always_ff @(posedge clock) begin
    if (reset) begin
      r_addr <= '0;
    end else if (w_addr_clr) begin
      r_addr <= '0;
    end else if (w_addr_inc) begin
      r_addr <= r_addr + ADDR_W'(1);
    end
  end

  // LED register: cleared on abort, loaded when ROM data is valid, else held
  always_ff @(posedge clock) begin
    if (reset) begin
      r_leds <= '0;
    end else if (w_leds_clr) begin
      r_leds <= '0;
    end else if (w_leds_load) begin
      r_leds <= bus.rom_data;
    end
  end

  // Done is a single-cycle pulse following the final step of a single pass
  always_ff @(posedge clock) begin
    if (reset) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_done_set;
    end
  end

  assign bus.rom_address = r_addr;
  assign bus.leds        = r_leds;
  assign bus.done        = r_done;
  assign bus.busy        = (r_state != C_ST_IDLE);

endmodule
`default_nettype wire
